// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: mode codes and shared defaults for the multi-mode flip-flop bank
package ff_bank_pkg;
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/ff_next_cell.sv
// ff_next_cell: next-state function of one SR/JK/D/T flip-flop bit
module ff_next_cell
    import ff_bank_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    output logic       q_next
);
    // SR 11 holds and JK 11 toggles; otherwise SR and JK share set/clear/hold
    always_comb begin
        q_next = mode == MODE_D  ? a :
                 mode == MODE_T  ? q ^ a :
                 (a && b)        ? (mode == MODE_JK ? ~q : q) :
                 a               ? 1'b1 :
                 b               ? 1'b0 : q;
    end
endmodule

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-bit flip-flop bank with runtime mode and SR-illegal error tracking
module multi_mode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = CNT_W_DEF,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Mode_wr,
    input  logic [1:0]       Mode_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic [1:0]       Mode,
    output logic             Illegal,
    output logic             Err_sticky,
    output logic [CNT_W-1:0] Err_cnt
);
    logic [WIDTH-1:0] q_next;
    logic             illegal_ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_next_cell u_cell (
            .mode   (Mode),
            .a      (A[i]),
            .b      (B[i]),
            .q      (Q[i]),
            .q_next (q_next[i])
        );
    end

    assign Q_bar      = ~Q;
    assign illegal_ev = En && Mode == MODE_SR && |(A & B);

    // Q follows the cells only when enabled; a mode write takes effect from the next edge
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q    <= INIT;
            Mode <= MODE_SR;
        end else begin
            if (En)
                Q <= q_next;
            if (Mode_wr)
                Mode <= Mode_in;
        end
    end

    // one error count per illegal cycle, saturating; a coinciding clear restarts the count at one
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Illegal    <= 1'b0;
            Err_sticky <= 1'b0;
            Err_cnt    <= '0;
        end else begin
            Illegal <= illegal_ev;
            if (illegal_ev) begin
                Err_sticky <= 1'b1;
                Err_cnt    <= Clr_err ? CNT_W'(1) : (&Err_cnt ? Err_cnt : Err_cnt + 1'b1);
            end else if (Clr_err) begin
                Err_sticky <= 1'b0;
                Err_cnt    <= '0;
            end
        end
    end
endmodule
